// File: rtl/seq_match_ctrl.sv
// Run-time programmable serial pattern matcher: one configured job at a time,
// counts overlapping matches until target, timeout or abort.
module seq_match_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [PAT_W-1:0] i_cfg_pattern,
  input  logic [3:0]       i_cfg_len,
  input  logic [CNT_W-1:0] i_cfg_target,
  input  logic [TO_W-1:0]  i_cfg_timeout,
  input  logic             i_abort,
  input  logic             i_data_valid,
  input  logic             i_data_in,
  output logic             o_flag,
  output logic [CNT_W-1:0] o_match_cnt,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_status
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [4:0]       LEN_MAX = 5'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);

  state_t             r_state;
  state_t             w_state_nx;
  logic [PAT_W-1:0]   r_pat;
  logic [3:0]         r_len;
  logic [CNT_W-1:0]   r_target;
  logic [TO_W-1:0]    r_timeout;
  logic [PAT_W-1:0]   r_shift;
  logic [3:0]         r_fill;
  logic [TO_W-1:0]    r_beats;
  logic [CNT_W-1:0]   r_match_cnt;
  logic [1:0]         r_status;
  logic               r_flag;
  logic               r_done;
  logic               r_busy;
  logic               r_cfg_ready;

  logic [PAT_W-1:0]   w_shift_nx;
  logic [3:0]         w_fill_nx;
  logic               w_match;
  logic               w_beat;
  logic               w_hit_tgt;
  logic               w_hit_to;
  logic               w_accept;
  logic               w_bad_cfg;

  // Ones in the low len bit positions; selects the active part of the pattern.
  function automatic logic [PAT_W-1:0] len_mask(input logic [3:0] len);
    logic [PAT_W-1:0] m;
    m = {PAT_W{1'b0}};
    for (int i = 0; i < PAT_W; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  // Match evaluation for the current beat and next-state selection.
  always_comb begin
    w_shift_nx = {r_shift[PAT_W-2:0], i_data_in};
    w_fill_nx  = (r_fill < r_len) ? (r_fill + 4'd1) : r_fill;
    w_match    = (w_fill_nx >= r_len) &&
                 (((w_shift_nx ^ r_pat) & len_mask(r_len)) == {PAT_W{1'b0}});
    w_beat     = (r_state == ST_RUN) && i_data_valid && !i_abort;
    w_hit_tgt  = w_beat && w_match && ((r_match_cnt + CNT_ONE) == r_target);
    w_hit_to   = w_beat && (r_timeout != {TO_W{1'b0}}) && ((r_beats + TO_ONE) == r_timeout);
    w_accept   = (r_state == ST_IDLE) && i_cfg_valid;
    w_bad_cfg  = (i_cfg_len == 4'd0) || ({1'b0, i_cfg_len} > LEN_MAX) ||
                 (i_cfg_target == {CNT_W{1'b0}});
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nx = w_bad_cfg ? ST_DONE : ST_RUN;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          w_state_nx = ST_IDLE;
        end else if (w_hit_tgt || w_hit_to) begin
          w_state_nx = ST_DONE;
        end else begin
          w_state_nx = ST_RUN;
        end
      end
      ST_DONE: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Config latch, match datapath and registered outputs decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat       <= {PAT_W{1'b0}};
      r_len       <= 4'd0;
      r_target    <= {CNT_W{1'b0}};
      r_timeout   <= {TO_W{1'b0}};
      r_shift     <= {PAT_W{1'b0}};
      r_fill      <= 4'd0;
      r_beats     <= {TO_W{1'b0}};
      r_match_cnt <= {CNT_W{1'b0}};
      r_status    <= 2'b00;
      r_flag      <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_cfg_ready <= 1'b1;
    end else begin
      r_flag      <= w_beat && w_match;
      r_done      <= (w_state_nx == ST_DONE);
      r_busy      <= (w_state_nx == ST_RUN);
      r_cfg_ready <= (w_state_nx == ST_IDLE);
      if (w_accept) begin
        r_pat       <= i_cfg_pattern;
        r_len       <= i_cfg_len;
        r_target    <= i_cfg_target;
        r_timeout   <= i_cfg_timeout;
        r_shift     <= {PAT_W{1'b0}};
        r_fill      <= 4'd0;
        r_beats     <= {TO_W{1'b0}};
        r_match_cnt <= {CNT_W{1'b0}};
        r_status    <= w_bad_cfg ? 2'b11 : 2'b00;
      end else if ((r_state == ST_RUN) && i_abort) begin
        r_status <= 2'b00;
      end else if (w_beat) begin
        r_shift <= w_shift_nx;
        r_fill  <= w_fill_nx;
        r_beats <= r_beats + TO_ONE;
        if (w_match) begin
          r_match_cnt <= r_match_cnt + CNT_ONE;
        end
        // Target completion takes priority over a coincident timeout.
        if (w_hit_tgt) begin
          r_status <= 2'b01;
        end else if (w_hit_to) begin
          r_status <= 2'b10;
        end
      end
    end
  end

  assign o_cfg_ready = r_cfg_ready;
  assign o_flag      = r_flag;
  assign o_match_cnt = r_match_cnt;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_status    = r_status;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed bench for seq_match_ctrl: stimulus pushes expected flag/done events
// into a queue, a negedge monitor pops and compares them against the DUT.
module tb_seq_match_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_cfg_valid = 1'b0;
  logic        o_cfg_ready;
  logic [7:0]  i_cfg_pattern = 8'd0;
  logic [3:0]  i_cfg_len = 4'd0;
  logic [7:0]  i_cfg_target = 8'd0;
  logic [15:0] i_cfg_timeout = 16'd0;
  logic        i_abort = 1'b0;
  logic        i_data_valid = 1'b0;
  logic        i_data_in = 1'b0;
  logic        o_flag;
  logic [7:0]  o_match_cnt;
  logic        o_busy;
  logic        o_done;
  logic [1:0]  o_status;

  typedef struct {
    int         cyc;
    logic       flag;
    logic       done;
    logic [7:0] cnt;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  seq_match_ctrl #(.PAT_W(8), .CNT_W(8), .TO_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cfg_valid  (i_cfg_valid),
    .o_cfg_ready  (o_cfg_ready),
    .i_cfg_pattern(i_cfg_pattern),
    .i_cfg_len    (i_cfg_len),
    .i_cfg_target (i_cfg_target),
    .i_cfg_timeout(i_cfg_timeout),
    .i_abort      (i_abort),
    .i_data_valid (i_data_valid),
    .i_data_in    (i_data_in),
    .o_flag       (o_flag),
    .o_match_cnt  (o_match_cnt),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_status     (o_status)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every flag/done pulse must match the head of the queue, in the expected cycle.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        total++;
        bad++;
        $display("FAIL missing_event expected_cyc=%0d now=%0d flag=%0d done=%0d", e.cyc, cyc, e.flag, e.done);
      end
      if (o_flag || o_done) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event cyc=%0d flag=%0d done=%0d cnt=%0d st=%0d", cyc, o_flag, o_done, o_match_cnt, o_status);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.flag !== o_flag || e.done !== o_done ||
              e.cnt !== o_match_cnt || e.st !== o_status) begin
            bad++;
            $display("FAIL sb_event got cyc=%0d flag=%0d done=%0d cnt=%0d st=%0d, need cyc=%0d flag=%0d done=%0d cnt=%0d st=%0d",
                     cyc, o_flag, o_done, o_match_cnt, o_status, e.cyc, e.flag, e.done, e.cnt, e.st);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int c, input logic f, input logic d, input logic [7:0] n, input logic [1:0] s);
    exp_t e;
    e.cyc = c; e.flag = f; e.done = d; e.cnt = n; e.st = s;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] tgt, input logic [15:0] to);
    i_cfg_valid   = 1'b1;
    i_cfg_pattern = pat;
    i_cfg_len     = len;
    i_cfg_target  = tgt;
    i_cfg_timeout = to;
    idle(1);
    i_cfg_valid   = 1'b0;
  endtask

  // One cycle with a data beat; optionally expects an event in the following cycle.
  task automatic beat(input logic b, input logic ef, input logic ed, input logic [7:0] ecnt, input logic [1:0] est);
    i_data_valid = 1'b1;
    i_data_in    = b;
    if (ef || ed) push(cyc + 1, ef, ed, ecnt, est);
    idle(1);
    i_data_valid = 1'b0;
  endtask

  task automatic beats_quiet(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) beat(bits[i], 1'b0, 1'b0, 8'd0, 2'd0);
  endtask

  initial begin
    logic [3:0] bad_len [3];
    logic [7:0] bad_tgt [3];
    bad_len = '{4'd0, 4'd9, 4'd1};
    bad_tgt = '{8'd1, 8'd1, 8'd0};

    #1 rst_n = 1'b0;
    #2;
    chk("rst_cfg_ready", 32'(o_cfg_ready), 32'd1);
    chk("rst_flag",      32'(o_flag),      32'd0);
    chk("rst_busy",      32'(o_busy),      32'd0);
    chk("rst_done",      32'(o_done),      32'd0);
    chk("rst_match_cnt", 32'(o_match_cnt), 32'd0);
    chk("rst_status",    32'(o_status),    32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Overlap: 101 over 1,0,1,0,1 -> matches at beats 3 and 5.
    cfg(8'h05, 4'd3, 8'd2, 16'd0);
    chk("run_busy", 32'(o_busy), 32'd1);
    beats_quiet(8'b10, 2);
    beat(1'b1, 1'b1, 1'b0, 8'd1, 2'd0);
    beat(1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    beat(1'b1, 1'b1, 1'b1, 8'd2, 2'd1);
    chk("done_busy",      32'(o_busy),      32'd0);
    chk("done_cfg_ready", 32'(o_cfg_ready), 32'd0);
    beat(1'b1, 1'b0, 1'b0, 8'd0, 2'd0);
    beat(1'b1, 1'b0, 1'b0, 8'd0, 2'd0);
    chk("hold_cfg_ready", 32'(o_cfg_ready), 32'd1);
    chk("hold_match_cnt", 32'(o_match_cnt), 32'd2);
    chk("hold_status",    32'(o_status),    32'd1);

    // Long pattern with junk in unused upper pattern bits.
    cfg(8'hE9, 4'd6, 8'd1, 16'd0);
    beats_quiet(8'b110100, 6);
    beat(1'b1, 1'b1, 1'b1, 8'd1, 2'd1);
    idle(1);

    // Timeout after 5 beats, with idle cycles inside the run.
    cfg(8'h0F, 4'd4, 8'd1, 16'd5);
    beats_quiet(8'b11, 2);
    idle(2);
    beats_quiet(8'b01, 2);
    beat(1'b1, 1'b0, 1'b1, 8'd0, 2'd2);
    idle(1);
    chk("to_match_cnt", 32'(o_match_cnt), 32'd0);
    chk("to_status",    32'(o_status),    32'd2);

    // Target and timeout on the same beat: target wins.
    cfg(8'h03, 4'd2, 8'd1, 16'd2);
    beat(1'b1, 1'b0, 1'b0, 8'd0, 2'd0);
    beat(1'b1, 1'b1, 1'b1, 8'd1, 2'd1);
    idle(1);

    // Bad configs: len 0, len > PAT_W, target 0.
    for (int k = 0; k < 3; k++) begin
      push(cyc + 1, 1'b0, 1'b1, 8'd0, 2'd3);
      cfg(8'h01, bad_len[k], bad_tgt[k], 16'd0);
      chk("bad_busy_done", 32'(o_busy), 32'd0);
      idle(1);
      chk("bad_busy_idle", 32'(o_busy),      32'd0);
      chk("bad_cfg_ready", 32'(o_cfg_ready), 32'd1);
      chk("bad_status",    32'(o_status),    32'd3);
    end

    // Config during RUN is ignored; the original pattern still matches.
    cfg(8'h05, 4'd3, 8'd1, 16'd0);
    beats_quiet(8'b10, 2);
    i_cfg_valid   = 1'b1;
    i_cfg_pattern = 8'h00;
    idle(1);
    i_cfg_valid   = 1'b0;
    chk("run_cfg_ready", 32'(o_cfg_ready), 32'd0);
    beat(1'b1, 1'b1, 1'b1, 8'd1, 2'd1);
    idle(1);

    // Abort with a would-be matching beat in the same cycle.
    cfg(8'h03, 4'd2, 8'd3, 16'd0);
    beat(1'b1, 1'b0, 1'b0, 8'd0, 2'd0);
    beat(1'b1, 1'b1, 1'b0, 8'd1, 2'd0);
    i_abort      = 1'b1;
    i_data_valid = 1'b1;
    i_data_in    = 1'b1;
    idle(1);
    i_abort      = 1'b0;
    i_data_valid = 1'b0;
    chk("abort_cfg_ready", 32'(o_cfg_ready), 32'd1);
    chk("abort_busy",      32'(o_busy),      32'd0);
    chk("abort_match_cnt", 32'(o_match_cnt), 32'd1);
    chk("abort_status",    32'(o_status),    32'd0);
    idle(2);
    cfg(8'h03, 4'd2, 8'd2, 16'd0);
    chk("new_job_cnt",  32'(o_match_cnt), 32'd0);
    chk("new_job_busy", 32'(o_busy),      32'd1);
    beat(1'b1, 1'b0, 1'b0, 8'd0, 2'd0);
    beat(1'b1, 1'b1, 1'b0, 8'd1, 2'd0);
    beat(1'b1, 1'b1, 1'b1, 8'd2, 2'd1);
    idle(1);

    // Asynchronous reset in the middle of a run.
    cfg(8'h01, 4'd1, 8'd5, 16'd0);
    beat(1'b1, 1'b1, 1'b0, 8'd1, 2'd0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_cfg_ready", 32'(o_cfg_ready), 32'd1);
    chk("arst_busy",      32'(o_busy),      32'd0);
    chk("arst_flag",      32'(o_flag),      32'd0);
    chk("arst_done",      32'(o_done),      32'd0);
    chk("arst_match_cnt", 32'(o_match_cnt), 32'd0);
    chk("arst_status",    32'(o_status),    32'd0);
    idle(1);
    rst_n = 1'b1;
    idle(2);
    chk("post_rst_cfg_ready", 32'(o_cfg_ready), 32'd1);

    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
